// File: rtl/ram_capture_reader.sv
// Pre/post-trigger sample capture into a circular buffer, then a
// valid/ready readout of the captured window in address order.

module true_dual_port_ram_dual_clock #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_a,
  input  logic                  clk_b,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  // Port A is the write side, port B the registered read side.
  always_ff @(posedge clk_a) begin
    if (we_a) ram[addr_a] <= data_a;
  end

  always_ff @(posedge clk_b) begin
    q_b <= ram[addr_b];
  end

endmodule

module ram_capture_reader #(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    wr,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    trig,
  input  logic [P_NBITS_ADDR:0]   n_pre,
  input  logic [P_NBITS_ADDR:0]   n_post,
  output logic [P_NBITS_DATA-1:0] q,
  output logic                    q_valid,
  input  logic                    q_ready,
  output logic                    q_last,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = P_NBITS_ADDR;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_READ} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]           wptr, trig_addr, start_addr, rd_addr;
  logic [AW:0]             n_pre_r, n_post_r, cnt_pre, post_cnt, rd_cnt;
  logic [AW:0]             total, post_eff, pre_eff, post_nxt;
  logic [AW+1:0]           req_sum;
  logic                    wr_en, trig_ok, accept, last_accept, out_free;
  logic                    rd_issue, rd_pend, rd_pend_last;
  logic                    skid_valid, skid_last;
  logic [1:0]              occ;
  logic [P_NBITS_DATA-1:0] ram_q, skid;

  // Request sanitising at arm time; n_post is also kept within the buffer.
  always_comb begin
    post_eff = n_post;
    if (n_post == '0)       post_eff = (AW+1)'(1);
    else if (n_post > DEPTH) post_eff = DEPTH;
    req_sum = {1'b0, n_pre} + {1'b0, post_eff};
    pre_eff = (req_sum > {1'b0, DEPTH}) ? DEPTH - post_eff : n_pre;
  end

  assign wr_en       = ((state == S_ARMED) || (state == S_POST)) && wr && !abort;
  assign trig_ok     = (state == S_ARMED) && wr && trig && !abort && (cnt_pre == n_pre_r);
  assign post_nxt    = post_cnt + (AW+1)'(1);
  assign total       = n_pre_r + n_post_r;
  assign start_addr  = trig_addr - n_pre_r[AW-1:0];
  assign rd_addr     = start_addr + rd_cnt[AW-1:0];
  assign accept      = q_valid && q_ready;
  assign last_accept = accept && q_last;
  assign out_free    = !q_valid || accept;
  assign busy        = (state != S_IDLE);

  // Words in flight or buffered never exceed the output and skid registers.
  assign occ      = 2'(rd_pend) + 2'(q_valid) + 2'(skid_valid);
  assign rd_issue = (state == S_READ) && !abort && (rd_cnt != total) &&
                    ((occ < 2'd2) || ((occ == 2'd2) && accept));

  true_dual_port_ram_dual_clock #(
    .DATA_WIDTH(P_NBITS_DATA),
    .ADDR_WIDTH(P_NBITS_ADDR)
  ) u_ram (
    .clk_a  (clk),
    .clk_b  (clk),
    .we_a   (wr_en),
    .addr_a (wptr),
    .data_a (d),
    .addr_b (rd_addr),
    .q_b    (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: if (trig_ok) state_nxt = (n_post_r == (AW+1)'(1)) ? S_READ : S_POST;
      S_POST:  if (wr_en && (post_nxt == n_post_r)) state_nxt = S_READ;
      S_READ:  if (last_accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      trig_addr    <= '0;
      n_pre_r      <= '0;
      n_post_r     <= '0;
      cnt_pre      <= '0;
      post_cnt     <= '0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      skid         <= '0;
      skid_valid   <= 1'b0;
      skid_last    <= 1'b0;
      q            <= '0;
      q_valid      <= 1'b0;
      q_last       <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) wptr <= wptr + AW'(1);
      if (abort) begin
        q_valid    <= 1'b0;
        skid_valid <= 1'b0;
        rd_pend    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arm) begin
              n_pre_r    <= pre_eff;
              n_post_r   <= post_eff;
              cnt_pre    <= '0;
              post_cnt   <= '0;
              rd_cnt     <= '0;
              q_valid    <= 1'b0;
              skid_valid <= 1'b0;
              rd_pend    <= 1'b0;
            end
          end
          S_ARMED: begin
            if (wr_en && (cnt_pre != n_pre_r)) cnt_pre <= cnt_pre + (AW+1)'(1);
            if (trig_ok) begin
              trig_addr <= wptr;
              post_cnt  <= (AW+1)'(1);
            end
          end
          S_POST: begin
            if (wr_en) post_cnt <= post_nxt;
          end
          S_READ: begin
            if (rd_issue) rd_cnt <= rd_cnt + (AW+1)'(1);
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (rd_cnt == total - (AW+1)'(1));
            done         <= last_accept;
            // The skid register catches the in-flight RAM word during a stall.
            if (out_free) begin
              if (skid_valid) begin
                q          <= skid;
                q_last     <= skid_last;
                q_valid    <= 1'b1;
                skid       <= ram_q;
                skid_last  <= rd_pend_last;
                skid_valid <= rd_pend;
              end else if (rd_pend) begin
                q       <= ram_q;
                q_last  <= rd_pend_last;
                q_valid <= 1'b1;
              end else begin
                q_valid <= 1'b0;
              end
            end else if (rd_pend) begin
              skid       <= ram_q;
              skid_last  <= rd_pend_last;
              skid_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_capture_reader.sv
// Directed bench for ram_capture_reader with a 16-entry buffer.

module tb_ram_capture_reader;

  localparam int A = 4;
  localparam int D = 14;

  logic         clk = 1'b0;
  logic         rst, arm, abort, wr, trig, q_ready;
  logic [D-1:0] d, q;
  logic [A:0]   n_pre, n_post;
  logic         q_valid, q_last, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int dc0;

  ram_capture_reader #(
    .P_NBITS_ADDR(A),
    .P_NBITS_DATA(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arm     (arm),
    .abort   (abort),
    .wr      (wr),
    .d       (d),
    .trig    (trig),
    .n_pre   (n_pre),
    .n_post  (n_post),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .q_last  (q_last),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int p, input int n);
    arm    = 1'b1;
    n_pre  = (A+1)'(p);
    n_post = (A+1)'(n);
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int v, input bit t);
    wr   = 1'b1;
    d    = D'(v);
    trig = t;
    tick();
    wr   = 1'b0;
    trig = 1'b0;
  endtask

  // Expected readout is the consecutive run first, first+1, ... of n words.
  task automatic readout(input string tag, input int n, input int first, input bit rnd);
    int idx = 0;
    int cyc = 0;
    int dstart = done_cnt;
    bit stall = 1'b0;
    int held = 0;
    while (idx < n && cyc < 400) begin
      q_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall) begin
        check({tag, "_hold_q"}, q, held);
        check({tag, "_hold_v"}, q_valid, 1);
      end
      stall = 1'b0;
      if (q_valid && q_ready) begin
        check({tag, "_word"}, q, first + idx);
        check({tag, "_last"}, q_last, (idx == n - 1) ? 1 : 0);
        idx++;
      end else if (q_valid) begin
        stall = 1'b1;
        held  = q;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_count"}, idx, n);
    q_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_qv_off"}, q_valid, 0);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_done_off"}, done, 0);
    check({tag, "_done_once"}, done_cnt - dstart, 1);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; wr = 1'b0; trig = 1'b0;
    q_ready = 1'b0; d = '0; n_pre = '0; n_post = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_last", q_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Basic window, with a stray arm while armed that must be ignored.
    do_arm(3, 2);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 7; i++) begin
      send(i, i == 5);
      if (i == 2) do_arm(0, 5);
    end
    check("t1_lat0", q_valid, 0);
    tick();
    check("t1_lat1", q_valid, 0);
    tick();
    check("t1_lat2", q_valid, 1);
    check("t1_first", q, 2);
    readout("t1", 5, 2, 1'b0);

    // Early trigger during pre-fill is ignored.
    do_arm(3, 2);
    for (int i = 0; i < 9; i++) send(i, (i == 1) || (i == 7));
    readout("t2", 5, 4, 1'b0);

    // Trigger at pointer 14: reads 10..15, 0, 1.
    do_arm(4, 4);
    for (int i = 0; i < 18; i++) send(20 + i, i == 14);
    readout("t3", 8, 30, 1'b0);

    // Random backpressure.
    do_arm(5, 5);
    for (int i = 0; i < 10; i++) send(50 + i, i == 5);
    readout("t4", 10, 50, 1'b1);

    // n_pre clamped to 8, full 16-word readout.
    do_arm(12, 8);
    for (int i = 0; i < 16; i++) send(60 + i, i == 8);
    readout("t5", 16, 60, 1'b0);

    // Abort in S_POST, together with arm.
    do_arm(2, 4);
    send(40, 1'b0); send(41, 1'b0); send(42, 1'b1); send(43, 1'b0);
    check("t6_post_busy", busy, 1);
    dc0 = done_cnt;
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    check("t6_abort_idle", busy, 0);
    check("t6_abort_qv", q_valid, 0);
    check("t6_abort_done", done, 0);
    tick(); tick();
    check("t6_no_done", done_cnt - dc0, 0);
    check("t6_still_idle", busy, 0);
    do_arm(1, 1);
    send(90, 1'b0); send(91, 1'b1);
    readout("t6_rearm", 2, 90, 1'b0);

    // Reset while a word is waiting in S_READ.
    do_arm(1, 2);
    send(80, 1'b0); send(81, 1'b1); send(82, 1'b0);
    q_ready = 1'b0;
    tick(); tick();
    check("t7_qv_pending", q_valid, 1);
    check("t7_q_pending", q, 80);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_qv", q_valid, 0);
    check("t7_rst_last", q_last, 0);
    check("t7_rst_q", q, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t7_no_done", done_cnt - dc0, 0);
    check("t7_idle", busy, 0);
    do_arm(1, 1);
    send(5, 1'b0); send(6, 1'b1);
    readout("t7_rearm", 2, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_capture_reader.md
RAM_CAPTURE_READER -- requirements
Module: ram_capture_reader

Interface
REQ-001 SHALL have parameter P_NBITS_ADDR, default 8, RAM address width; buffer depth is 2^P_NBITS_ADDR.
REQ-002 SHALL have parameter P_NBITS_DATA, default 14, sample width.
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock only.
REQ-004 SHALL have port rst  input  1  system reset, asynchronous, active-high.
REQ-005 SHALL have port arm  input  1  one-cycle pulse that starts a capture.
REQ-006 SHALL have port abort  input  1  forces a return to idle from any state.
REQ-007 SHALL have port wr  input  1  sample strobe.
REQ-008 SHALL have port d  input  P_NBITS_DATA  input sample.
REQ-009 SHALL have port trig  input  1  trigger, qualified by wr.
REQ-010 SHALL have port n_pre  input  P_NBITS_ADDR+1  pre-trigger sample count.
REQ-011 SHALL have port n_post  input  P_NBITS_ADDR+1  post-trigger sample count, trigger sample included.
REQ-012 SHALL have port q  output  P_NBITS_DATA  readout data.
REQ-013 SHALL have port q_valid  output  1  readout word available.
REQ-014 SHALL have port q_ready  input  1  downstream accepts q.
REQ-015 SHALL have port q_last  output  1  marks the final readout word; qualified by q_valid.
REQ-016 SHALL have port busy  output  1  high in every state other than S_IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-018 SHALL store samples in one true_dual_port_ram_dual_clock instance, with both clocks tied to clk; port A writes and port B reads with 1-cycle read latency.
REQ-019 SHALL implement the states S_IDLE, S_ARMED, S_POST and S_READ.
REQ-020 SHALL move S_IDLE->S_ARMED on arm, sampling n_pre and n_post, and SHALL clear the pre-fill counter.
REQ-021 SHALL ignore arm in every state except S_IDLE.
REQ-022 SHALL use n_post=1 in place of a sampled n_post of 0.
REQ-023 SHALL replace n_pre with 2^P_NBITS_ADDR - n_post when n_pre + n_post exceeds 2^P_NBITS_ADDR.
REQ-024 SHALL, in S_ARMED and S_POST on each wr, write d to the write pointer and then increment the pointer modulo 2^P_NBITS_ADDR (natural wrap).
REQ-025 SHALL NOT write the RAM in S_IDLE or S_READ.
REQ-026 SHALL, in S_ARMED, count wr samples up to n_pre, saturating at n_pre.
REQ-027 SHALL accept trig only in S_ARMED, only with wr, and only when the pre-fill count already equals n_pre before that sample.
REQ-028 SHALL ignore trig in every other case.
REQ-029 SHALL, on an accepted trigger, latch the trigger address T (the address of that cycle's write) and count that sample as post sample 1.
REQ-030 SHALL move S_ARMED->S_POST on an accepted trigger when n_post>1, and S_ARMED->S_READ when n_post=1.
REQ-031 SHALL move S_POST->S_READ on the wr that writes post sample n_post.
REQ-032 SHALL set the start address to T - n_pre, modulo 2^P_NBITS_ADDR.
REQ-033 SHALL read out n_pre+n_post words in address order from the start address, wrapping.
REQ-034 SHALL assert q_valid for the first word exactly 2 cycles after entering S_READ.
REQ-035 SHALL hold q and q_last stable while q_valid=1 and q_ready=0.
REQ-036 SHALL complete a transfer on q_valid && q_ready.
REQ-037 SHALL sustain 1 word per cycle while q_ready is held high, with no drop and no duplicate (prefetch or skid register as needed).
REQ-038 SHALL assert q_last with the word numbered n_pre+n_post.
REQ-039 SHALL, on acceptance of the last word, deassert q_valid the next cycle, pulse done for 1 cycle and enter S_IDLE.
REQ-040 SHALL, on abort in any state, enter S_IDLE the next cycle, drop q_valid, produce no done pulse and discard pending data.
REQ-041 SHALL give abort priority over arm, trig and wr in the same cycle.
REQ-042 SHALL make the write pointer free-running across captures; it is not cleared by arm.

Reset
REQ-043 SHALL, on rst, asynchronously force state=S_IDLE, q_valid=0, q_last=0, busy=0, done=0, write pointer=0 and all counters=0.
REQ-044 SHALL set q=0 on reset.
REQ-045 SHALL NOT clear the RAM contents on reset.
REQ-046 SHALL treat rst asserted mid-capture or mid-readout the same as abort, with no done pulse.

Verification
REQ-047 SHALL cover: A=4, arm, n_pre=3, n_post=2, wr continuous with d=0,1,2..., trig with d=5 -> readout 2,3,4,5,6, q_last on 6, done once.
REQ-048 SHALL cover: trig on sample 1 (pre-fill incomplete), then trig on d=7, n_pre=3 -> first trigger ignored; readout starts 4.
REQ-049 SHALL cover: write pointer at 14 (A=4) at trigger, n_pre=4, n_post=4 -> read addresses 10..15, 0, 1; data matches the wrapped writes.
REQ-050 SHALL cover: q_ready toggled randomly during readout -> q stable while stalled, every word delivered once and in order, done after the last acceptance.
REQ-051 SHALL cover: n_pre=12, n_post=8 (A=4) -> n_pre clamped to 8; 16 words read.
REQ-052 SHALL cover: abort during S_POST, and separately rst during S_READ -> S_IDLE next cycle, q_valid=0, no done; a following arm captures normally.
